// File: rtl/cacheline_bmem_adapter.sv
// cacheline_bmem_adapter: splits 256-bit cache line reads/writebacks into 4-beat 64-bit bmem bursts
module cacheline_bmem_adapter #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int BEATS = 4,
  localparam int LINE_W = BEAT_W * BEATS,
  localparam int CNT_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_t;
  state_t state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic last;
  assign cnt_nx = beat_cnt + CNT_W'(1);
  assign last = beat_cnt == CNT_W'(BEATS - 1);
  // bmem_addr doubles as the latched line address used to tag-match read beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat_cnt <= '0;
      dfp_rdata <= '0;
      dfp_resp <= 1'b0;
      bmem_addr <= '0;
      bmem_read <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (dfp_write) begin
            state <= WR_BURST;
            bmem_write <= 1'b1;
            bmem_wdata <= dfp_wdata[BEAT_W-1:0];
            bmem_addr <= dfp_addr & LINE_MASK;
          end else if (dfp_read) begin
            state <= RD_REQ;
            bmem_read <= 1'b1;
            bmem_addr <= dfp_addr & LINE_MASK;
          end
        end
        RD_REQ: if (bmem_ready) begin
          state <= RD_WAIT;
          bmem_read <= 1'b0;
          beat_cnt <= '0;
        end
        RD_WAIT: if (bmem_rvalid && bmem_raddr == bmem_addr) begin
          dfp_rdata[BEAT_W*beat_cnt +: BEAT_W] <= bmem_rdata;
          beat_cnt <= cnt_nx;
          if (last) begin
            state <= RESP;
            dfp_resp <= 1'b1;
            bmem_addr <= '0;
          end
        end
        WR_BURST: if (bmem_ready) begin
          beat_cnt <= cnt_nx;
          bmem_wdata <= dfp_wdata[BEAT_W*cnt_nx +: BEAT_W];
          if (last) begin
            state <= RESP;
            dfp_resp <= 1'b1;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
            bmem_addr <= '0;
          end
        end
        RESP: begin
          state <= IDLE;
          dfp_resp <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  a_no_dual_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(state == IDLE && dfp_read && dfp_write));
endmodule

// File: tb/tb_cacheline_bmem_adapter.sv
// tb_cacheline_bmem_adapter: directed checks of line read/write bursting
module tb_cacheline_bmem_adapter;
  logic clk = 0, rst_n = 0;
  logic [31:0] dfp_addr = 0, bmem_addr, bmem_raddr = 0;
  logic dfp_read = 0, dfp_write = 0, dfp_resp, bmem_read, bmem_write;
  logic bmem_ready = 0, bmem_rvalid = 0;
  logic [255:0] dfp_wdata = 0, dfp_rdata;
  logic [63:0] bmem_wdata, bmem_rdata = 0;
  int checks = 0, failures = 0;

  cacheline_bmem_adapter dut (
    .clk(clk), .rst_n(rst_n), .dfp_addr(dfp_addr), .dfp_read(dfp_read),
    .dfp_write(dfp_write), .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata),
    .dfp_resp(dfp_resp), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
    .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #2;
    checks++;
    if ({dfp_resp, bmem_read, bmem_write} !== 3'b000 || bmem_addr !== 0 || bmem_wdata !== 0 || dfp_rdata !== 0) begin
      failures++;
      $display("FAIL reset_outputs: resp/rd/wr=%b addr=%h wdata=%h rdata=%h, required all zero",
               {dfp_resp, bmem_read, bmem_write}, bmem_addr, bmem_wdata, dfp_rdata);
    end
    tick();
    rst_n = 1;
    tick();
    checks++;
    if ({dfp_resp, bmem_read, bmem_write} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle: resp/rd/wr=%b, required 000", {dfp_resp, bmem_read, bmem_write});
    end
  endtask

  task automatic test_read_basic();
    logic [63:0] b[4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                          64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    int resp_cnt = 0;
    dfp_addr = 32'h0000_1024;
    dfp_read = 1;
    bmem_ready = 1;
    tick();
    checks++;
    if (bmem_read !== 1 || bmem_addr !== 32'h1020) begin
      failures++;
      $display("FAIL rd_req: read=%b addr=%h, required 1 00001020", bmem_read, bmem_addr);
    end
    tick();
    checks++;
    if (bmem_read !== 0) begin
      failures++;
      $display("FAIL rd_req_one_cycle: read=%b, required 0", bmem_read);
    end
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1;
      bmem_raddr = 32'h1020;
      bmem_rdata = b[i];
      if (dfp_resp) resp_cnt++;
      tick();
    end
    bmem_rvalid = 0;
    checks++;
    if (dfp_resp !== 1 || resp_cnt != 0 || dfp_rdata !== {b[3], b[2], b[1], b[0]}) begin
      failures++;
      $display("FAIL rd_line: resp=%b early=%0d rdata=%h, required 1 0 %h", dfp_resp, resp_cnt,
               dfp_rdata, {b[3], b[2], b[1], b[0]});
    end
    dfp_read = 0;
    tick();
    checks++;
    if (dfp_resp !== 0 || bmem_addr !== 0) begin
      failures++;
      $display("FAIL rd_resp_pulse: resp=%b addr=%h, required 0 00000000", dfp_resp, bmem_addr);
    end
  endtask

  task automatic test_write_stream();
    logic [63:0] b[4] = '{64'hAAAA_AAAA_0000_000A, 64'hBBBB_BBBB_0000_000B,
                          64'hCCCC_CCCC_0000_000C, 64'hDDDD_DDDD_0000_000D};
    dfp_addr = 32'h2000;
    dfp_wdata = {b[3], b[2], b[1], b[0]};
    dfp_write = 1;
    bmem_ready = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bmem_write !== 1 || bmem_wdata !== b[i] || bmem_addr !== 32'h2000 || dfp_resp !== 0) begin
        failures++;
        $display("FAIL wr_beat%0d: write=%b wdata=%h addr=%h resp=%b, required 1 %h 00002000 0",
                 i, bmem_write, bmem_wdata, bmem_addr, dfp_resp, b[i]);
      end
      tick();
    end
    checks++;
    if (bmem_write !== 0 || dfp_resp !== 1) begin
      failures++;
      $display("FAIL wr_done: write=%b resp=%b, required 0 1", bmem_write, dfp_resp);
    end
    dfp_write = 0;
    tick();
    checks++;
    if (dfp_resp !== 0 || bmem_write !== 0) begin
      failures++;
      $display("FAIL wr_resp_pulse: resp=%b write=%b, required 0 0", dfp_resp, bmem_write);
    end
  endtask

  task automatic test_write_stall();
    logic [63:0] b[4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                          64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
    logic pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int acc = 0;
    dfp_addr = 32'h2040;
    dfp_wdata = {b[3], b[2], b[1], b[0]};
    dfp_write = 1;
    tick();
    for (int i = 0; i < 7; i++) begin
      bmem_ready = pat[i];
      checks++;
      if (bmem_write !== 1 || bmem_wdata !== b[acc] || dfp_resp !== 0) begin
        failures++;
        $display("FAIL stall_cyc%0d: write=%b wdata=%h resp=%b, required 1 %h 0",
                 i, bmem_write, bmem_wdata, dfp_resp, b[acc]);
      end
      tick();
      if (pat[i]) acc++;
    end
    checks++;
    if (dfp_resp !== 1 || bmem_write !== 0) begin
      failures++;
      $display("FAIL stall_done: resp=%b write=%b, required 1 0", dfp_resp, bmem_write);
    end
    dfp_write = 0;
    bmem_ready = 1;
    tick();
  endtask

  task automatic test_foreign_beats();
    logic [31:0] ra[8] = '{32'h1020, 32'h3000, 32'h1020, 32'h3000, 32'h3000, 32'h1020, 32'h1020, 32'h1020};
    logic vld[8] = '{1, 1, 1, 1, 0, 1, 1, 0};
    logic [63:0] rd[8] = '{64'h0101_0101_0101_0101, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0202_0202_0202_0202,
                           64'hBAD0_BAD0_BAD0_BAD0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0303_0303_0303_0303,
                           64'h0404_0404_0404_0404, 64'h0};
    dfp_addr = 32'h101F + 32'h1;
    dfp_read = 1;
    bmem_ready = 1;
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      bmem_rvalid = vld[i];
      bmem_raddr = ra[i];
      bmem_rdata = rd[i];
      checks++;
      if (dfp_resp !== 0) begin
        failures++;
        $display("FAIL foreign_early_resp%0d: resp=%b, required 0", i, dfp_resp);
      end
      tick();
    end
    bmem_rvalid = 0;
    checks++;
    if (dfp_resp !== 1 || dfp_rdata !== {rd[6], rd[5], rd[2], rd[0]}) begin
      failures++;
      $display("FAIL foreign_line: resp=%b rdata=%h, required 1 %h", dfp_resp, dfp_rdata,
               {rd[6], rd[5], rd[2], rd[0]});
    end
    dfp_read = 0;
    tick();
  endtask

  task automatic test_read_stall();
    logic [63:0] b[4] = '{64'hA1, 64'hB2, 64'hC3, 64'hD4};
    dfp_addr = 32'h4010;
    dfp_read = 1;
    bmem_ready = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bmem_read !== 1 || bmem_addr !== 32'h4000) begin
        failures++;
        $display("FAIL rd_hold%0d: read=%b addr=%h, required 1 00004000", i, bmem_read, bmem_addr);
      end
      tick();
    end
    bmem_ready = 1;
    tick();
    checks++;
    if (bmem_read !== 0) begin
      failures++;
      $display("FAIL rd_hold_release: read=%b, required 0", bmem_read);
    end
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1;
      bmem_raddr = 32'h4000;
      bmem_rdata = b[i];
      tick();
    end
    bmem_rvalid = 0;
    checks++;
    if (dfp_resp !== 1 || dfp_rdata !== {b[3], b[2], b[1], b[0]}) begin
      failures++;
      $display("FAIL rd_hold_line: resp=%b rdata=%h, required 1 %h", dfp_resp, dfp_rdata,
               {b[3], b[2], b[1], b[0]});
    end
    dfp_read = 0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] b[4] = '{64'h6000_0000_0000_0001, 64'h6000_0000_0000_0002,
                          64'h6000_0000_0000_0003, 64'h6000_0000_0000_0004};
    int resp_cnt = 0;
    dfp_addr = 32'h5000;
    dfp_wdata = {4{64'h7777_8888_9999_AAAA}};
    dfp_write = 1;
    bmem_ready = 1;
    tick();
    tick();
    tick();
    rst_n = 0;
    #1;
    checks++;
    if (bmem_write !== 0 || bmem_addr !== 0 || dfp_resp !== 0 || dfp_rdata !== 0) begin
      failures++;
      $display("FAIL midrst_drop: write=%b addr=%h resp=%b rdata=%h, required 0 0 0 0",
               bmem_write, bmem_addr, dfp_resp, dfp_rdata);
    end
    dfp_write = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dfp_resp) resp_cnt++;
    end
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (dfp_resp) resp_cnt++;
    end
    checks++;
    if (resp_cnt != 0 || bmem_write !== 0) begin
      failures++;
      $display("FAIL midrst_noresp: resp pulses=%0d write=%b, required 0 0", resp_cnt, bmem_write);
    end
    dfp_addr = 32'h6000;
    dfp_read = 1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1;
      bmem_raddr = 32'h6000;
      bmem_rdata = b[i];
      tick();
    end
    bmem_rvalid = 0;
    checks++;
    if (dfp_resp !== 1 || dfp_rdata !== {b[3], b[2], b[1], b[0]}) begin
      failures++;
      $display("FAIL midrst_read: resp=%b rdata=%h, required 1 %h", dfp_resp, dfp_rdata,
               {b[3], b[2], b[1], b[0]});
    end
    dfp_read = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_stream();
    test_write_stall();
    test_foreign_beats();
    test_read_stall();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
